seq_bit_tx: RTL and testbench
=============================

# seq_bit_tx

Serial bit-stream transmitter that drives the single-bit `in` input of the sequential pattern-detector block. It accepts parallel words over a valid/ready handshake, shifts them out MSB first, one bit per clock, and inserts a programmable idle gap between frames. It serves as the stimulus source in the block-level environment and as the front end of any synthesized path feeding the detector.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 2..32.
- `GAP`, default 2: idle cycles forced between frames; legal range 0..15.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  parallel word available.
- `in_data`  input  WIDTH  parallel word; sampled on handshake.
- `in_ready`  output  1  block can accept a word this cycle.
- `out`  output  1  serial data bit, registered.
- `out_valid`  output  1  `out` carries a frame bit this cycle.
- `busy`  output  1  frame or gap in progress.
- `done`  output  1  one-cycle pulse on the final bit of a frame.

## Operation
- Reset values: `in_ready`=1, `out`=0, `out_valid`=0, `busy`=0, `done`=0; state IDLE, shift register and counters cleared.
- States: IDLE, SHIFT, PAR (only with `SEQ_TX_PARITY_EN`), GAP.
- IDLE: `in_ready`=1. Handshake = `in_valid && in_ready` at a rising edge; loads `in_data` into the shift register, bit counter = WIDTH-1, goes to SHIFT.
- SHIFT: `out` = shift-register MSB, `out_valid`=1; register shifts left each cycle with 0 fill; counter decrements. At counter 0: go to PAR if parity enabled, else to GAP (GAP>0) or IDLE (GAP=0).
- PAR: one cycle, `out` = parity bit, `out_valid`=1; then GAP or IDLE as above.
- GAP: `out`=0, `out_valid`=0, `busy`=1 for exactly GAP cycles (counter reload GAP-1, decrement to 0), then IDLE.
- `in_ready`=0 in every state except IDLE; `in_valid` and `in_data` are ignored there, no buffering.
- `busy`=1 in SHIFT, PAR, GAP.
- `done`=1 in the cycle carrying the last frame bit (last data bit, or parity bit when enabled).
- Outside SHIFT/PAR, `out` is forced 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the partial frame is dropped, no `done`.
- Counters sized for the maximum parameter values; no wrap-around inside a frame.

## Timing
- Handshake at edge N: MSB on `out` with `out_valid`=1 during cycle N..N+1 (first cycle after the edge).
- Frame length on the wire: WIDTH cycles (WIDTH+1 with parity).
- Throughput: one frame per WIDTH+GAP+1 cycles (IDLE spends one cycle accepting); +1 with parity.
- GAP=0: IDLE re-entered the cycle after the last bit; the next handshake occurs at that cycle's end, giving exactly one idle bit between frames.
- All outputs come straight from flops; no combinational input-to-output path except none (`in_ready` is state-decoded).

## Configuration
- `SEQ_TX_PARITY_EN` defined: PAR state is present; an even-parity bit (XOR of the WIDTH data bits) follows the data bits, `done` moves to the parity cycle.
- Not defined: no PAR state, frame is data bits only, parity logic is absent from the netlist.

## Test plan
- Reset then WIDTH=8, GAP=2, send 0xA5 -> `out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `out_valid`=1, `done` on 8th bit, then 2 cycles `busy`=1/`out_valid`=0, then `in_ready`=1.
- Parity build, send 0xA5 then 0x07 -> parity bit 0 after 0xA5, 1 after 0x07; `done` on the parity cycles.
- `in_valid` held high with 0x3C, 0xFF, 0x00 back-to-back -> each frame starts exactly WIDTH+GAP+1 cycles after the previous; words presented while `in_ready`=0 are not consumed.
- Assert `rst` for one cycle during bit 4 of 0xF0 -> `out`, `out_valid`, `busy`, `done` drop to 0 at once, no `done` for that frame, `in_ready`=1 after release; next word 0x81 transmits cleanly.
- GAP=0, WIDTH=2, send 2'b10 then 2'b11 -> wire shows 1,0,(idle 0),1,1 with `out_valid` low only during the idle bit.

Source files
------------

// File: rtl/seq_bit_tx.sv
// seq_bit_tx: serial bit-stream transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake, shifts it out MSB
// first one bit per clock, then holds the line idle for GAP cycles.
//
// Build option: SEQ_TX_PARITY_EN adds an even-parity bit after the data bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   parallel word available
//   in_data    parallel word, sampled on handshake
//   in_ready   ready to accept a word (IDLE only)
//   out        serial bit (0 when no frame bit is on the wire)
//   out_valid  out carries a frame bit
//   busy       frame or gap in progress
//   done       pulse on the last frame bit
//
// state   | meaning
// S_IDLE  | waiting for a word, in_ready high
// S_SHIFT | data bits on the wire, counter = bits left after current one
// S_PAR   | parity bit on the wire (parity build only)
// S_GAP   | forced idle between frames, counter = gap cycles left minus one
//
// Every output is a flop: the next-cycle value is decoded together with the
// next state and registered alongside it.

module seq_bit_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    // Wide enough for WIDTH-1 (max 31) and GAP-1 (max 14).
    localparam int CW = $clog2((WIDTH > 16) ? WIDTH : 16);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? (GAP - 1) : 0);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_sreg, w_sreg_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_out, w_out_nx;
    logic             r_out_valid, w_out_valid_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             r_in_ready, w_in_ready_nx;
    logic             w_frame_end;
`ifdef SEQ_TX_PARITY_EN
    logic             r_par, w_par_nx;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_sreg_nx      = r_sreg;
        w_cnt_nx       = r_cnt;
        w_out_nx       = 1'b0;
        w_out_valid_nx = 1'b0;
        w_busy_nx      = 1'b0;
        w_done_nx      = 1'b0;
        w_in_ready_nx  = 1'b0;
        w_frame_end    = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        w_par_nx       = r_par;
`endif

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    // MSB goes straight to the output flop; the register keeps the rest.
                    w_state_nx     = S_SHIFT;
                    w_out_nx       = in_data[WIDTH-1];
                    w_sreg_nx      = {in_data[WIDTH-2:0], 1'b0};
                    w_cnt_nx       = CNT_LOAD;
                    w_out_valid_nx = 1'b1;
                    w_busy_nx      = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    w_par_nx       = ^in_data;
`endif
                end else begin
                    w_in_ready_nx = 1'b1;
                end
            end

            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_out_nx       = r_sreg[WIDTH-1];
                    w_sreg_nx      = {r_sreg[WIDTH-2:0], 1'b0};
                    w_cnt_nx       = r_cnt - CW'(1);
                    w_out_valid_nx = 1'b1;
                    w_busy_nx      = 1'b1;
`ifndef SEQ_TX_PARITY_EN
                    w_done_nx      = (r_cnt == CW'(1));
`endif
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    w_state_nx     = S_PAR;
                    w_out_nx       = r_par;
                    w_out_valid_nx = 1'b1;
                    w_busy_nx      = 1'b1;
                    w_done_nx      = 1'b1;
`else
                    w_frame_end    = 1'b1;
`endif
                end
            end

`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                w_frame_end = 1'b1;
            end
`endif

            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx    = S_IDLE;
                    w_in_ready_nx = 1'b1;
                end else begin
                    w_cnt_nx  = r_cnt - CW'(1);
                    w_busy_nx = 1'b1;
                end
            end

            default: begin
                w_state_nx    = S_IDLE;
                w_in_ready_nx = 1'b1;
            end
        endcase

        if (w_frame_end) begin
            if (GAP > 0) begin
                w_state_nx = S_GAP;
                w_cnt_nx   = GAP_LOAD;
                w_busy_nx  = 1'b1;
            end else begin
                w_state_nx    = S_IDLE;
                w_in_ready_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_sreg      <= w_sreg_nx;
            r_cnt       <= w_cnt_nx;
            r_out       <= w_out_nx;
            r_out_valid <= w_out_valid_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_in_ready  <= w_in_ready_nx;
`ifdef SEQ_TX_PARITY_EN
            r_par       <= w_par_nx;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_seq_bit_tx.sv
// Testbench for seq_bit_tx: two instances (WIDTH=8/GAP=2 and WIDTH=2/GAP=0).
// The reference model treats each instance as a box that, once it takes a word,
// puts its bits on the wire on the following cycles and is unavailable for a
// fixed frame period; expected wire bits go into a scoreboard queue and a
// negedge monitor compares every cycle.

module tb_seq_bit_tx;

`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam int W0 = 8, G0 = 2;
    localparam int W1 = 2, G1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic [7:0]  dat_a = '0;
    logic [1:0]  dat_b = '0;
    logic        rdy_a, out_a, ov_a, busy_a, done_a;
    logic        rdy_b, out_b, ov_b, busy_b, done_b;

    seq_bit_tx #(.WIDTH(W0), .GAP(G0)) u_dut_a (
        .clk(clk), .rst(rst_a), .in_valid(vld_a), .in_data(dat_a),
        .in_ready(rdy_a), .out(out_a), .out_valid(ov_a), .busy(busy_a), .done(done_a));

    seq_bit_tx #(.WIDTH(W1), .GAP(G1)) u_dut_b (
        .clk(clk), .rst(rst_b), .in_valid(vld_b), .in_data(dat_b),
        .in_ready(rdy_b), .out(out_b), .out_valid(ov_b), .busy(busy_b), .done(done_b));

    typedef struct {
        int id;
        int cyc;
        bit b;
        bit d;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ready_edge[2] = '{0, 0};
    int   acc[2] = '{0, 0};
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, id, cyc, act, exp);
        end
    endtask

    function automatic int wid(input int id);
        return (id == 0) ? W0 : W1;
    endfunction

    function automatic int gapc(input int id);
        return (id == 0) ? G0 : G1;
    endfunction

    function automatic void flush(input int id);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].id == id) q.delete(i);
    endfunction

    // Model: a word taken at edge E appears on cycles E..E+len-1; the block
    // takes its next word no earlier than edge E+len+gap+1.
    function automatic void accept(input int id, input logic [31:0] d);
        int w, ones, len;
        exp_t e;
        w = wid(id);
        len = w + PAR;
        ones = 0;
        for (int k = 0; k < w; k++) begin
            e.id  = id;
            e.cyc = cyc + k;
            e.b   = ((d >> (w - 1 - k)) & 1) != 0;
            e.d   = (k == len - 1);
            if (e.b) ones++;
            q.push_back(e);
        end
        if (PAR != 0) begin
            e.id  = id;
            e.cyc = cyc + w;
            e.b   = (ones % 2) != 0;
            e.d   = 1'b1;
            q.push_back(e);
        end
        ready_edge[id] = cyc + len + gapc(id) + 1;
        acc[id]++;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst_a) ready_edge[0] = cyc + 1;
        else if (vld_a && cyc >= ready_edge[0]) accept(0, {24'd0, dat_a});
        if (rst_b) ready_edge[1] = cyc + 1;
        else if (vld_b && cyc >= ready_edge[1]) accept(1, {30'd0, dat_b});
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int id = 0; id < 2; id++) begin
                logic o, ov, r, bz, dn, rdy_exp, exp_v;
                int idx;
                o  = (id == 0) ? out_a  : out_b;
                ov = (id == 0) ? ov_a   : ov_b;
                r  = (id == 0) ? rdy_a  : rdy_b;
                bz = (id == 0) ? busy_a : busy_b;
                dn = (id == 0) ? done_a : done_b;
                rdy_exp = (cyc + 1 >= ready_edge[id]);
                chk("in_ready", id, {31'd0, r}, {31'd0, rdy_exp});
                chk("busy", id, {31'd0, bz}, {31'd0, !rdy_exp});
                idx = -1;
                for (int i = 0; i < q.size(); i++)
                    if (q[i].id == id && idx < 0) idx = i;
                while (idx >= 0 && q[idx].cyc < cyc) begin
                    chk("missed_bit", id, 32'(q[idx].cyc), 32'(cyc));
                    q.delete(idx);
                    idx = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].id == id && idx < 0) idx = i;
                end
                exp_v = (idx >= 0) && (q[idx].cyc == cyc);
                chk("out_valid", id, {31'd0, ov}, {31'd0, exp_v});
                if (exp_v) begin
                    chk("out_bit", id, {31'd0, o}, {31'd0, q[idx].b});
                    chk("done", id, {31'd0, dn}, {31'd0, q[idx].d});
                    q.delete(idx);
                end else begin
                    chk("out_idle", id, {31'd0, o}, 32'd0);
                    chk("done_idle", id, {31'd0, dn}, 32'd0);
                end
            end
        end
    end

    task automatic drive(input int id, input bit v, input logic [31:0] d);
        if (id == 0) begin vld_a = v; dat_a = d[7:0]; end
        else         begin vld_b = v; dat_b = d[1:0]; end
    endtask

    task automatic send(input int id, input logic [31:0] d, input bit hold);
        int start, t;
        start = acc[id];
        t = 0;
        @(negedge clk);
        drive(id, 1'b1, d);
        while (acc[id] == start && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc[id] == start) chk("accept_timeout", id, 32'(t), 32'd0);
        if (!hold) begin
            @(negedge clk);
            drive(id, 1'b0, d);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 0, 32'(q.size()), 32'd0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 0, {31'd0, rdy_a}, 32'd1);
        chk("rst_out", 0, {31'd0, out_a}, 32'd0);
        chk("rst_out_valid", 0, {31'd0, ov_a}, 32'd0);
        chk("rst_busy", 0, {31'd0, busy_a}, 32'd0);
        chk("rst_done", 0, {31'd0, done_a}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        mon_en = 1'b1;

        send(0, 32'hA5, 1'b0);
        drain();
        send(0, 32'hA5, 1'b0);
        send(0, 32'h07, 1'b0);
        drain();

        send(0, 32'h3C, 1'b1);
        send(0, 32'hFF, 1'b1);
        send(0, 32'h00, 1'b0);
        drain();

        send(1, 32'h2, 1'b1);
        send(1, 32'h3, 1'b0);
        drain();

        send(0, 32'hF0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_a = 1'b1;
        flush(0);
        #1;
        chk("mid_rst_out", 0, {31'd0, out_a}, 32'd0);
        chk("mid_rst_out_valid", 0, {31'd0, ov_a}, 32'd0);
        chk("mid_rst_busy", 0, {31'd0, busy_a}, 32'd0);
        chk("mid_rst_done", 0, {31'd0, done_a}, 32'd0);
        chk("mid_rst_in_ready", 0, {31'd0, rdy_a}, 32'd1);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        send(0, 32'h81, 1'b0);
        drain();

        for (int n = 0; n < 30; n++) begin
            int id;
            id = int'($urandom_range(0, 1));
            send(id, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'd0);
        drive(1, 1'b0, 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
